rr_tristate_bus_arbiter: RTL and testbench

//   Parametrised successor of the enable-gated 4-bit tri-state buffer. NCH sources share one

---
 rtl/rr_tristate_bus_arbiter.sv | 110 +++++++++++
 tb/tb_rr_tristate_bus_arbiter.sv | 135 +++++++++++++
 2 files changed

// File: rtl/rr_tristate_bus_arbiter.sv
// Round-robin arbiter granting NCH sources a shared registered tri-state bus; data latency one cycle.
// Sources hold req while they have data; en=0 freezes all state and floats the bus.
module rr_tristate_bus_arbiter #(
  parameter int WIDTH    = 4,
  parameter int NCH      = 4,
  parameter int MAX_HOLD = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic [NCH-1:0]             req,
  input  logic [NCH*WIDTH-1:0]       data_in,
  output logic [NCH-1:0]             gnt,
  output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] owner,
  output logic                       bus_valid,
  output wire  [WIDTH-1:0]           bus_out
);

  localparam int OW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HW-1:0] HOLD_SAT = (MAX_HOLD > 0) ? HW'(MAX_HOLD) : {HW{1'b1}};

  typedef enum logic {IDLE, OWN} state_t;

  state_t           state, state_nx;
  logic [NCH-1:0]   gnt_nx;
  logic [OW-1:0]    owner_nx, ptr, ptr_nx, pick;
  logic             bus_valid_nx, any_req, others_req;
  logic [WIDTH-1:0] bus_reg, bus_reg_nx;
  logic [HW-1:0]    hold_cnt, hold_cnt_nx;
  int               idx;

  // First requester at or after ptr, wrapping at NCH-1.
  always_comb begin
    pick    = '0;
    any_req = 1'b0;
    idx     = 0;
    for (int off = 0; off < NCH; off++) begin
      idx = int'(ptr) + off;
      if (idx >= NCH) idx = idx - NCH;
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        pick    = OW'(idx);
      end
    end
  end

  assign others_req = |(req & ~gnt);

  always_comb begin
    state_nx     = state;
    gnt_nx       = gnt;
    owner_nx     = owner;
    bus_valid_nx = bus_valid;
    bus_reg_nx   = bus_reg;
    ptr_nx       = ptr;
    hold_cnt_nx  = hold_cnt;
    if (en) begin
      case (state)
        IDLE: begin
          if (any_req) begin
            gnt_nx       = NCH'(1) << pick;
            owner_nx     = pick;
            bus_reg_nx   = data_in[int'(pick)*WIDTH +: WIDTH];
            bus_valid_nx = 1'b1;
            hold_cnt_nx  = HW'(1);
            state_nx     = OWN;
          end
        end
        OWN: begin
          if (!req[owner] || (MAX_HOLD != 0 && hold_cnt == HOLD_SAT && others_req)) begin
            // Release: the bus floats for at least one cycle before the next grant.
            gnt_nx       = '0;
            bus_valid_nx = 1'b0;
            ptr_nx       = (owner == OW'(NCH - 1)) ? '0 : owner + 1'b1;
            hold_cnt_nx  = '0;
            state_nx     = IDLE;
          end else begin
            bus_reg_nx = data_in[int'(owner)*WIDTH +: WIDTH];
            if (hold_cnt != HOLD_SAT) hold_cnt_nx = hold_cnt + 1'b1;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      gnt       <= '0;
      owner     <= '0;
      bus_valid <= 1'b0;
      bus_reg   <= '0;
      ptr       <= '0;
      hold_cnt  <= '0;
    end else begin
      state     <= state_nx;
      gnt       <= gnt_nx;
      owner     <= owner_nx;
      bus_valid <= bus_valid_nx;
      bus_reg   <= bus_reg_nx;
      ptr       <= ptr_nx;
      hold_cnt  <= hold_cnt_nx;
    end
  end

  assign bus_out = (bus_valid && en) ? bus_reg : {WIDTH{1'bz}};

endmodule

// File: tb/tb_rr_tristate_bus_arbiter.sv
// Directed bench for rr_tristate_bus_arbiter (WIDTH=4, NCH=4, MAX_HOLD=3); a floating bus reads 4'hF via pullups.
module tb_rr_tristate_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b1;
  logic [3:0]  req = '0;
  logic [15:0] data_in = '0;
  logic [3:0]  gnt;
  logic [1:0]  owner;
  logic        bus_valid;
  wire  [3:0]  bus_w;

  pullup (bus_w[0]);
  pullup (bus_w[1]);
  pullup (bus_w[2]);
  pullup (bus_w[3]);

  rr_tristate_bus_arbiter #(.WIDTH(4), .NCH(4), .MAX_HOLD(3)) dut (
    .clk(clk), .reset(reset), .en(en), .req(req), .data_in(data_in),
    .gnt(gnt), .owner(owner), .bus_valid(bus_valid), .bus_out(bus_w)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        en;
    logic [3:0]  req;
    logic [15:0] din;
    logic [3:0]  gnt;
    logic        vld;
    logic [3:0]  bus;
  } vec_t;

  vec_t vt[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [3:0] e_gnt, input logic e_vld,
                       input logic [3:0] e_bus);
    logic [1:0] e_own;
    n_vec++;
    e_own = '0;
    for (int i = 0; i < 4; i++) if (e_gnt[i]) e_own = 2'(i);
    if (gnt !== e_gnt) begin
      n_bad++;
      $display("FAIL %s gnt got %b want %b", name, gnt, e_gnt);
    end
    if (bus_valid !== e_vld) begin
      n_bad++;
      $display("FAIL %s bus_valid got %b want %b", name, bus_valid, e_vld);
    end
    if (bus_w !== e_bus) begin
      n_bad++;
      $display("FAIL %s bus got %h want %h", name, bus_w, e_bus);
    end
    if (e_gnt != 4'b0 && owner !== e_own) begin
      n_bad++;
      $display("FAIL %s owner got %0d want %0d", name, owner, e_own);
    end
  endtask

  initial begin
    // {rst, en, req, data {d3,d2,d1,d0}, gnt, bus_valid, bus (F = floating)}
    vt.push_back('{1'b1, 1'b1, 4'b0000, 16'h0000, 4'b0000, 1'b0, 4'hF});
    vt.push_back('{1'b1, 1'b1, 4'b0000, 16'h0000, 4'b0000, 1'b0, 4'hF});
    vt.push_back('{1'b0, 1'b1, 4'b0000, 16'h0000, 4'b0000, 1'b0, 4'hF});
    vt.push_back('{1'b0, 1'b1, 4'b0001, 16'h0005, 4'b0001, 1'b1, 4'h5});
    vt.push_back('{1'b0, 1'b1, 4'b0001, 16'h0006, 4'b0001, 1'b1, 4'h6});
    vt.push_back('{1'b0, 1'b1, 4'b0000, 16'h0006, 4'b0000, 1'b0, 4'hF});
    vt.push_back('{1'b1, 1'b1, 4'b0000, 16'h0000, 4'b0000, 1'b0, 4'hF});
    vt.push_back('{1'b0, 1'b1, 4'b0011, 16'h0081, 4'b0001, 1'b1, 4'h1});
    vt.push_back('{1'b0, 1'b1, 4'b0011, 16'h0082, 4'b0001, 1'b1, 4'h2});
    vt.push_back('{1'b0, 1'b1, 4'b0011, 16'h0083, 4'b0001, 1'b1, 4'h3});
    vt.push_back('{1'b0, 1'b1, 4'b0011, 16'h0084, 4'b0000, 1'b0, 4'hF});
    vt.push_back('{1'b0, 1'b1, 4'b0011, 16'h0094, 4'b0010, 1'b1, 4'h9});
    vt.push_back('{1'b0, 1'b1, 4'b0011, 16'h00A4, 4'b0010, 1'b1, 4'hA});
    vt.push_back('{1'b0, 1'b1, 4'b0001, 16'h00B4, 4'b0000, 1'b0, 4'hF});
    vt.push_back('{1'b0, 1'b1, 4'b0101, 16'h0C04, 4'b0100, 1'b1, 4'hC});
    vt.push_back('{1'b0, 1'b1, 4'b0001, 16'h0D04, 4'b0000, 1'b0, 4'hF});
    vt.push_back('{1'b0, 1'b1, 4'b0001, 16'h0004, 4'b0001, 1'b1, 4'h4});
    vt.push_back('{1'b0, 1'b1, 4'b1001, 16'h7005, 4'b0001, 1'b1, 4'h5});
    vt.push_back('{1'b0, 1'b1, 4'b1001, 16'h7006, 4'b0001, 1'b1, 4'h6});
    vt.push_back('{1'b0, 1'b1, 4'b1001, 16'h7002, 4'b0000, 1'b0, 4'hF});
    vt.push_back('{1'b0, 1'b1, 4'b1001, 16'h7002, 4'b1000, 1'b1, 4'h7});
    vt.push_back('{1'b0, 1'b1, 4'b0000, 16'h0000, 4'b0000, 1'b0, 4'hF});

    for (int v = 0; v < vt.size(); v++) begin
      reset   = vt[v].rst;
      en      = vt[v].en;
      req     = vt[v].req;
      data_in = vt[v].din;
      tick();
      check($sformatf("vec%0d", v), vt[v].gnt, vt[v].vld, vt[v].bus);
    end

    // Enable gating while ch1 owns the bus.
    req = 4'b0010; data_in = 16'h0030;
    tick();                      check("en_grant", 4'b0010, 1'b1, 4'h3);
    en = 1'b0; data_in = 16'h0040;
    #1;                          check("en_off_comb", 4'b0010, 1'b1, 4'hF);
    tick();                      check("en_off_1", 4'b0010, 1'b1, 4'hF);
    data_in = 16'h0050;
    tick();                      check("en_off_2", 4'b0010, 1'b1, 4'hF);
    en = 1'b1; data_in = 16'h0060;
    #1;                          check("en_on_old", 4'b0010, 1'b1, 4'h3);
    tick();                      check("en_on_new", 4'b0010, 1'b1, 4'h6);

    // Reset mid-ownership, then lone requester past MAX_HOLD is not preempted.
    reset = 1'b1;
    tick();                      check("rst_mid", 4'b0000, 1'b0, 4'hF);
    reset = 1'b0; req = 4'b1000; data_in = 16'h9000;
    tick();                      check("post_rst", 4'b1000, 1'b1, 4'h9);
    for (int i = 1; i <= 5; i++) begin
      data_in = {4'(i), 12'h000};
      tick();
      check($sformatf("lone_hold%0d", i), 4'b1000, 1'b1, 4'(i));
    end
    req = 4'b1001; data_in = 16'h6002;
    tick();                      check("preempt3", 4'b0000, 1'b0, 4'hF);
    tick();                      check("wrap_ch0", 4'b0001, 1'b1, 4'h2);
    req = 4'b0000;
    tick();                      check("final_rel", 4'b0000, 1'b0, 4'hF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
